// File: rtl/boid_frame_plotter_pkg.sv
// Shared constants and FSM encoding for the boid display-RAM writer.
// The VGA controller and the top-level wrapper import the same values.
package boid_frame_plotter_pkg;

  localparam int DEF_VIDEO_WIDTH    = 640;
  localparam int DEF_VIDEO_HEIGHT   = 480;
  localparam int DEF_ADDR_WIDTH     = 19;
  localparam int DEF_MAX_BOIDS      = 4;
  localparam int DEF_BITS_FOR_BOIDS = 2;
  localparam int DEF_BOID_SIZE      = 2;

  // Width of the in-square pixel offsets; covers square edges up to 4.
  localparam int DELTA_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SELECT,
    ST_LATCH,
    ST_PLOT,
    ST_DONE
  } plot_state_t;

endpackage

// File: rtl/boid_pixel_addr.sv
// Combinational pixel address for one square pixel: (bx+dx, by+dy) -> linear
// display-RAM address plus an on-screen flag.
module boid_pixel_addr
  import boid_frame_plotter_pkg::*;
#(
  parameter int VIDEO_WIDTH  = DEF_VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = DEF_VIDEO_HEIGHT,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) (
  input  logic [9:0]            bx,
  input  logic [8:0]            by,
  input  logic [DELTA_W-1:0]    dx,
  input  logic [DELTA_W-1:0]    dy,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_bounds
);

  logic [ADDR_WIDTH-1:0] px;
  logic [ADDR_WIDTH-1:0] py;

  always_comb begin
    // Widen before adding so a square hanging off the edge still compares as off-screen.
    px        = ADDR_WIDTH'(bx) + ADDR_WIDTH'(dx);
    py        = ADDR_WIDTH'(by) + ADDR_WIDTH'(dy);
    // py*640 as 512+128; tied to a 640-pixel line.
    addr      = (py << 9) + (py << 7) + px;
    in_bounds = (px < ADDR_WIDTH'(VIDEO_WIDTH)) && (py < ADDR_WIDTH'(VIDEO_HEIGHT));
  end

endmodule

// File: rtl/boid_frame_plotter.sv
// Frame-end writer for the boid display RAM: clear, then scan every BPU slot
// and plot a BOID_SIZE x BOID_SIZE square at its position.
module boid_frame_plotter
  import boid_frame_plotter_pkg::*;
#(
  parameter int MAX_BOIDS      = DEF_MAX_BOIDS,
  parameter int BITS_FOR_BOIDS = DEF_BITS_FOR_BOIDS,
  parameter int VIDEO_WIDTH    = DEF_VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT   = DEF_VIDEO_HEIGHT,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int BOID_SIZE      = DEF_BOID_SIZE
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      screen_end,
  output logic [BITS_FOR_BOIDS-1:0] boid_sel,
  input  logic [9:0]                x_in,
  input  logic [8:0]                y_in,
  output logic                      mem_clear,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic                      busy,
  output logic                      frame_done
);

  localparam logic [DELTA_W-1:0]        D_LAST   = DELTA_W'(BOID_SIZE - 1);
  localparam logic [BITS_FOR_BOIDS-1:0] IDX_LAST = BITS_FOR_BOIDS'(MAX_BOIDS - 1);

  plot_state_t               state, state_nxt;
  logic [BITS_FOR_BOIDS-1:0] idx, idx_nxt;
  logic [9:0]                bx, bx_nxt;
  logic [8:0]                by, by_nxt;
  logic [DELTA_W-1:0]        dx, dx_nxt, dy, dy_nxt;
  logic                      pending, pending_nxt;

  logic [BITS_FOR_BOIDS-1:0] boid_sel_nxt;
  logic                      mem_clear_nxt, mem_we_nxt, busy_nxt, frame_done_nxt;
  logic [ADDR_WIDTH-1:0]     mem_addr_nxt;

  logic [ADDR_WIDTH-1:0]     pix_addr;
  logic                      pix_in_bounds;

  // Evaluated on the upcoming pixel so mem_addr/mem_we can be registered
  // and still line up with the PLOT cycle they belong to.
  boid_pixel_addr #(
    .VIDEO_WIDTH (VIDEO_WIDTH),
    .VIDEO_HEIGHT(VIDEO_HEIGHT),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) u_pixel_addr (
    .bx       (bx_nxt),
    .by       (by_nxt),
    .dx       (dx_nxt),
    .dy       (dy_nxt),
    .addr     (pix_addr),
    .in_bounds(pix_in_bounds)
  );

  always_comb begin
    // NOTE: every target gets a default first, so no path through the case can infer a latch.
    state_nxt   = state;
    idx_nxt     = idx;
    bx_nxt      = bx;
    by_nxt      = by;
    dx_nxt      = dx;
    dy_nxt      = dy;
    pending_nxt = pending;

    // One frame request can queue behind the running frame; extra pulses merge into it.
    if (screen_end && (state != ST_IDLE)) pending_nxt = 1'b1;

    case (state)
      ST_IDLE:   if (screen_end) state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        idx_nxt   = '0;
        state_nxt = ST_SELECT;
      end
      ST_SELECT: state_nxt = ST_LATCH;
      ST_LATCH: begin
        bx_nxt    = x_in;
        by_nxt    = y_in;
        dx_nxt    = '0;
        dy_nxt    = '0;
        state_nxt = ST_PLOT;
      end
      ST_PLOT: begin
        if (dx == D_LAST) begin
          dx_nxt = '0;
          if (dy == D_LAST) begin
            if (idx == IDX_LAST) begin
              state_nxt = ST_DONE;
            end else begin
              idx_nxt   = idx + 1'b1;
              state_nxt = ST_SELECT;
            end
          end else begin
            dy_nxt = dy + 1'b1;
          end
        end else begin
          dx_nxt = dx + 1'b1;
        end
      end
      ST_DONE: begin
        pending_nxt = 1'b0;
        state_nxt   = (pending || screen_end) ? ST_CLEAR : ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase

    mem_clear_nxt  = (state_nxt == ST_CLEAR);
    frame_done_nxt = (state_nxt == ST_DONE);
    busy_nxt       = (state_nxt != ST_IDLE);
    boid_sel_nxt   = (state_nxt == ST_SELECT) ? idx_nxt : boid_sel;
    mem_we_nxt     = (state_nxt == ST_PLOT) && pix_in_bounds;
    mem_addr_nxt   = (state_nxt == ST_PLOT) ? pix_addr : mem_addr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      bx         <= '0;
      by         <= '0;
      dx         <= '0;
      dy         <= '0;
      pending    <= 1'b0;
      boid_sel   <= '0;
      mem_clear  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples pre-edge values regardless of order.
      state      <= state_nxt;
      idx        <= idx_nxt;
      bx         <= bx_nxt;
      by         <= by_nxt;
      dx         <= dx_nxt;
      dy         <= dy_nxt;
      pending    <= pending_nxt;
      boid_sel   <= boid_sel_nxt;
      mem_clear  <= mem_clear_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_boid_frame_plotter.sv
// Directed bench for boid_frame_plotter: a four-slot BPU mux model feeds
// x_in/y_in, and every frame is traced cycle by cycle from the CLEAR cycle.
module tb_boid_frame_plotter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        screen_end = 1'b0;
  logic [1:0]  boid_sel;
  logic [9:0]  x_in;
  logic [8:0]  y_in;
  logic        mem_clear, mem_we, busy, frame_done;
  logic [18:0] mem_addr;

  logic [9:0]  x_tab [4];
  logic [8:0]  y_tab [4];
  logic        scramble = 1'b0;
  logic        latch_win = 1'b0;
  logic [9:0]  junk_x = '0;
  logic [8:0]  junk_y = '0;

  int errors = 0;
  int checks = 0;

  // Trace of the last run_frame call; cycle 0 is the first cycle after the pulse.
  int we_q[$];
  int clr_q[$];
  int done_q[$];
  int busy_cnt;

  // Expected write sequence for boids (0,0),(10,5),(638,479),(100,200).
  int exp_std[14] = '{0, 1, 640, 641, 3210, 3211, 3850, 3851,
                      307198, 307199, 128100, 128101, 128740, 128741};

  assign x_in = (scramble && !latch_win) ? junk_x : x_tab[boid_sel];
  assign y_in = (scramble && !latch_win) ? junk_y : y_tab[boid_sel];

  boid_frame_plotter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .screen_end(screen_end),
    .boid_sel  (boid_sel),
    .x_in      (x_in),
    .y_in      (y_in),
    .mem_clear (mem_clear),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_std_boids();
    x_tab = '{10'd0, 10'd10, 10'd638, 10'd100};
    y_tab = '{9'd0, 9'd5, 9'd479, 9'd200};
  endtask

  // Pulses screen_end once, then traces ncyc cycles. inj_a/inj_b are cycles in
  // which screen_end is raised again (-1 for none). LATCH of boid i is cycle 2+6i.
  task automatic run_frame(input int ncyc, input int inj_a, input int inj_b);
    we_q.delete();
    clr_q.delete();
    done_q.delete();
    busy_cnt = 0;
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    for (int t = 0; t < ncyc; t++) begin
      latch_win  = (t >= 2) && (((t - 2) % 6) == 0);
      junk_x     = 10'($urandom_range(0, 1023));
      junk_y     = 9'($urandom_range(0, 511));
      screen_end = (t == inj_a) || (t == inj_b);
      if (mem_clear)  clr_q.push_back(t);
      if (frame_done) done_q.push_back(t);
      if (busy)       busy_cnt++;
      if (mem_we)     we_q.push_back(int'(mem_addr));
      tick();
    end
    screen_end = 1'b0;
    latch_win  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      screen_end = (i == 1);
      tick();
      checks++;
      if ({mem_clear, mem_we, busy, frame_done} !== 4'b0 || mem_addr !== 19'd0 || boid_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold: clr=%b we=%b busy=%b done=%b addr=%0d sel=%0d, required all 0",
                 mem_clear, mem_we, busy, frame_done, mem_addr, boid_sel);
      end
    end
    screen_end = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || mem_clear !== 1'b0) begin
        errors++;
        $display("FAIL reset_release_idle: busy=%b clr=%b, required 0 0", busy, mem_clear);
      end
    end
  endtask

  task automatic test_basic_frame();
    set_std_boids();
    run_frame(40, -1, -1);
    checks++;
    if (clr_q.size() != 1 || clr_q[0] != 0) begin
      errors++;
      $display("FAIL basic_clear: pulses=%0d first=%0d, required 1 pulse at cycle 0",
               clr_q.size(), (clr_q.size() > 0) ? clr_q[0] : -1);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != 25) begin
      errors++;
      $display("FAIL basic_frame_done: pulses=%0d at=%0d, required 1 pulse at cycle 25",
               done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
    end
    checks++;
    if (busy_cnt != 26) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d cycles, required 26", busy_cnt);
    end
    checks++;
    if (we_q.size() != 14) begin
      errors++;
      $display("FAIL basic_write_count: got %0d, required 14", we_q.size());
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (i >= we_q.size() || we_q[i] != exp_std[i]) begin
        errors++;
        $display("FAIL basic_addr[%0d]: got %0d, required %0d", i,
                 (i < we_q.size()) ? we_q[i] : -1, exp_std[i]);
      end
    end
    checks++;
    if (boid_sel !== 2'd3) begin
      errors++;
      $display("FAIL sel_hold: got %0d, required 3", boid_sel);
    end
  endtask

  task automatic test_clipping();
    x_tab = '{10'd639, 10'd700, 10'd700, 10'd700};
    y_tab = '{9'd479, 9'd0, 9'd0, 9'd0};
    run_frame(40, -1, -1);
    checks++;
    if (we_q.size() != 1 || we_q[0] != 307199) begin
      errors++;
      $display("FAIL clip_writes: count=%0d first=%0d, required 1 write at 307199",
               we_q.size(), (we_q.size() > 0) ? we_q[0] : -1);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] != 25 || busy_cnt != 26) begin
      errors++;
      $display("FAIL clip_timing: done_at=%0d busy=%0d, required 25 and 26",
               (done_q.size() > 0) ? done_q[0] : -1, busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    set_std_boids();
    // Cycles 4 and 10 fall inside PLOT of boid 0 and boid 1.
    run_frame(70, 4, 10);
    checks++;
    if (clr_q.size() != 2 || clr_q[0] != 0 || clr_q[1] != 26) begin
      errors++;
      $display("FAIL b2b_clear: pulses=%0d second=%0d, required 2 pulses at 0 and 26",
               clr_q.size(), (clr_q.size() > 1) ? clr_q[1] : -1);
    end
    checks++;
    if (done_q.size() != 2 || done_q[1] != 51) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d second=%0d, required 2 pulses, second at 51",
               done_q.size(), (done_q.size() > 1) ? done_q[1] : -1);
    end
    checks++;
    if (busy_cnt != 52 || we_q.size() != 28) begin
      errors++;
      $display("FAIL b2b_span: busy=%0d writes=%0d, required 52 and 28", busy_cnt, we_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_after: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_plot();
    set_std_boids();
    screen_end = 1'b1;
    tick();
    screen_end = 1'b0;
    // Cycle 16 is the (dx=1,dy=0) pixel of boid 2 at (638,479).
    repeat (16) tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 19'd307199) begin
      errors++;
      $display("FAIL midplot_pre: we=%b addr=%0d, required 1 and 307199", mem_we, mem_addr);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || boid_sel !== 2'd0) begin
      errors++;
      $display("FAIL midplot_async_reset: we=%b busy=%b sel=%0d, required 0 0 0", mem_we, busy, boid_sel);
    end
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    run_frame(40, -1, -1);
    checks++;
    if (done_q.size() != 1 || done_q[0] != 25 || busy_cnt != 26) begin
      errors++;
      $display("FAIL midplot_refresh_timing: done_at=%0d busy=%0d, required 25 and 26",
               (done_q.size() > 0) ? done_q[0] : -1, busy_cnt);
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (i >= we_q.size() || we_q[i] != exp_std[i]) begin
        errors++;
        $display("FAIL midplot_addr[%0d]: got %0d, required %0d", i,
                 (i < we_q.size()) ? we_q[i] : -1, exp_std[i]);
      end
    end
  endtask

  task automatic test_latch_only_sampling();
    set_std_boids();
    scramble = 1'b1;
    run_frame(40, -1, -1);
    scramble = 1'b0;
    checks++;
    if (we_q.size() != 14) begin
      errors++;
      $display("FAIL latch_write_count: got %0d, required 14", we_q.size());
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (i >= we_q.size() || we_q[i] != exp_std[i]) begin
        errors++;
        $display("FAIL latch_addr[%0d]: got %0d, required %0d", i,
                 (i < we_q.size()) ? we_q[i] : -1, exp_std[i]);
      end
    end
  endtask

  initial begin
    set_std_boids();
    test_reset();
    test_basic_frame();
    test_clipping();
    test_back_to_back();
    test_reset_mid_plot();
    test_latch_only_sampling();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
